seq_det_param: RTL and testbench

//  Parametrised serial pattern detector; generalises the fixed 1011 detector.

---
 rtl/seq_det_pkg.sv | 10 +
 rtl/seq_det_sat_cnt.sv | 23 ++
 rtl/seq_det_param.sv | 87 ++++++++
 tb/tb_seq_det_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {S_FILL, S_HUNT} seq_det_state_t;

    localparam int         SEQ_DET_PAT_W       = 4;
    localparam logic [3:0] SEQ_DET_DEFAULT_PAT = 4'b1011;
    localparam logic [3:0] SEQ_DET_DEFAULT_MSK = 4'b1111;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: increments on inc, holds at all-ones instead of wrapping.
module seq_det_sat_cnt #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {COUNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with runtime-loadable pattern/mask and overlap control.
// Optional match counter built only when SEQ_DET_COUNT_EN is defined.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W   = SEQ_DET_PAT_W,
    parameter logic [PATTERN_W-1:0] DEFAULT_PAT = PATTERN_W'(SEQ_DET_DEFAULT_PAT),
    parameter int                   COUNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_bit,
    input  logic                 in_valid,
    input  logic                 mode_ovl,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
    input  logic [PATTERN_W-1:0] pat_mask,
    output logic                 detected,
    output logic [COUNT_W-1:0]   match_count
);

    localparam int               FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    seq_det_state_t       r_state;
    logic [PATTERN_W-1:0] r_win;
    logic [PATTERN_W-1:0] r_pat;
    logic [PATTERN_W-1:0] r_mask;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_det;

    logic [PATTERN_W-1:0] w_win_n;
    logic [FILL_W-1:0]    w_fill_n;
    logic                 w_match;

    assign w_win_n  = {r_win[PATTERN_W-2:0], in_bit};
    // In S_HUNT the window is already full, so fill simply stays saturated.
    assign w_fill_n = (r_state == S_HUNT) ? FILL_FULL : r_fill + 1'b1;
    assign w_match  = in_valid && !pat_load && (w_fill_n == FILL_FULL)
                      && (((w_win_n ^ r_pat) & r_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_win   <= '0;
            r_pat   <= DEFAULT_PAT;
            r_mask  <= '1;
            r_fill  <= '0;
            r_det   <= 1'b0;
        end else begin
            r_det <= 1'b0;
            if (pat_load) begin
                r_pat   <= pat_in;
                r_mask  <= pat_mask;
                r_fill  <= '0;
                r_state <= S_FILL;
            end else if (in_valid) begin
                r_win <= w_win_n;
                r_det <= w_match;
                if (w_match && !mode_ovl) begin
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_fill  <= w_fill_n;
                    r_state <= (w_fill_n == FILL_FULL) ? S_HUNT : S_FILL;
                end
            end
        end
    end

    assign detected = r_det;

`ifdef SEQ_DET_COUNT_EN
    // Counter advances on the same edge that raises detected, so both move together.
    seq_det_sat_cnt #(
        .COUNT_W (COUNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_match),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Table-driven bench for seq_det_param: one vector per cycle, expectations queued and
// compared on the following negedge.
module tb_seq_det_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_bit, in_valid, mode_ovl, pat_load;
    logic [3:0] pat_in, pat_mask;
    logic       detected;
    logic [1:0] match_count;

    seq_det_param #(
        .PATTERN_W   (4),
        .DEFAULT_PAT (4'b1011),
        .COUNT_W     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .mode_ovl    (mode_ovl),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .pat_mask    (pat_mask),
        .detected    (detected),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, v, b, ld, ovl;
        logic [3:0] pat, msk;
        logic       e;
    } vec_t;

    typedef struct {
        logic       det;
        logic [1:0] cnt;
        int         idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    logic cur_ovl;
    logic [1:0] tally;
    int checks = 0;
    int errors = 0;

    task automatic add(input logic r, v, b, ld, input logic [3:0] pat, msk, input logic e);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.ld = ld; t.ovl = cur_ovl;
        t.pat = pat; t.msk = msk; t.e = e;
        tbl.push_back(t);
    endtask

    task automatic bits(input string s, input string e);
        for (int i = 0; i < s.len(); i++)
            add(1'b0, 1'b1, s[i] == 8'h31, 1'b0, 4'h0, 4'h0, e[i] == 8'h31);
    endtask

    task automatic do_rst(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic check_one();
        exp_t x;
        if (sb.size() == 0) return;
        x = sb.pop_front();
        checks++;
        if (detected !== x.det) begin
            errors++;
            $display("FAIL det[%0d]: got %0b, expected %0b", x.idx, detected, x.det);
        end
        checks++;
        if (match_count !== x.cnt) begin
            errors++;
            $display("FAIL cnt[%0d]: got %0d, expected %0d", x.idx, match_count, x.cnt);
        end
    endtask

    initial begin
        exp_t x;
        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; mode_ovl = 1'b0;
        pat_load = 1'b0; pat_in = '0; pat_mask = '0;
        tally = '0;

        // reset, then overlapping default 1011 search
        cur_ovl = 1'b1;
        do_rst(2);
        bits("1011011", "0001001");
        // reset mid-stream: old partial window must not complete a match
        bits("101", "000");
        do_rst(2);
        bits("1011", "0001");
        // non-overlapping mode
        do_rst(1);
        cur_ovl = 1'b0;
        bits("1011011", "0001000");
        // stalls inside the pattern, with a tempting bit value while invalid
        do_rst(1);
        cur_ovl = 1'b1;
        bits("10", "00");
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        bits("11", "01");
        // masked pattern load (bit alongside load is discarded), then abort via reload
        do_rst(1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 4'b1110, 1'b0);
        bits("1101", "0001");
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b1111, 1'b0);
        bits("10", "00");
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1111, 1'b0);
        bits("1011", "0001");
        // all-zero mask: every bit once the window is full
        do_rst(1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        bits("01100", "00011");
        // five overlapping matches saturate a 2-bit counter
        do_rst(1);
        bits("1011011011011011", "0001001001001001");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check_one();
            rst      = tbl[i].r;
            in_valid = tbl[i].v;
            in_bit   = tbl[i].b;
            pat_load = tbl[i].ld;
            mode_ovl = tbl[i].ovl;
            pat_in   = tbl[i].pat;
            pat_mask = tbl[i].msk;
            if (tbl[i].r) tally = '0;
            else if (tbl[i].e && tally != 2'd3) tally = tally + 2'd1;
            x.det = tbl[i].e;
            x.cnt = CNT_EN ? tally : 2'd0;
            x.idx = i;
            sb.push_back(x);
        end
        @(negedge clk);
        check_one();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
